// File: rtl/hex_frag_serializer.sv
// Double-buffered hex-cell batch capture with per-cell fragment serialization.
// Optional radius clipping of cells is enabled by defining HEX_CLIP_EN.
module hex_frag_serializer #(
    parameter int BATCH  = 10,
    parameter int RADIUS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic signed [15:0] q_in     [0:BATCH-1],
    input  logic signed [15:0] r_in     [0:BATCH-1],
    input  logic        [7:0]  depth_in [0:BATCH-1],
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_q,
    output logic signed [15:0] out_r,
    output logic        [7:0]  out_depth,
    output logic        [3:0]  out_slot,
    output logic               out_last,
    output logic               overflow,
    output logic        [15:0] clip_count
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t state, state_nx;

    logic signed [15:0] buf_q     [0:1][0:BATCH-1];
    logic signed [15:0] buf_r     [0:1][0:BATCH-1];
    logic        [7:0]  buf_depth [0:1][0:BATCH-1];
    logic [BATCH-1:0]   buf_keep  [0:1];
    logic [1:0]         buf_valid;
    logic               wr_ptr, rd_ptr, rd_ptr_nx;
    logic [1:0]         occupancy;
    logic [3:0]         slot, slot_nx;
    logic [BATCH-1:0]   new_keep;
    logic               capture, free_buf;
    logic [4:0]         cur_next, own_first, oth_first, new_first;

    function automatic logic within_radius(logic signed [15:0] q, logic signed [15:0] r);
        logic signed [16:0] s;
        int aq, ar, as;
        s  = 17'(q) + 17'(r);
        aq = (q < 0) ? -int'(q) : int'(q);
        ar = (r < 0) ? -int'(r) : int'(r);
        as = (s < 0) ? -int'(s) : int'(s);
        return (aq <= RADIUS) && (ar <= RADIUS) && (as <= RADIUS);
    endfunction

    // Lowest kept slot at or above 'from': {found, index}.
    function automatic logic [4:0] next_kept(logic [BATCH-1:0] mask, int unsigned from);
        logic [4:0] res;
        res = '0;
        for (int unsigned i = 0; i < BATCH; i++) begin
            if (!res[4] && mask[i] && (i >= from))
                res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

    assign in_ready = (occupancy != 2'd2);
    assign capture  = valid_in && in_ready;

    always_comb begin
        state_nx  = state;
        slot_nx   = slot;
        rd_ptr_nx = rd_ptr;
        free_buf  = 1'b0;
        cur_next  = next_kept(buf_keep[rd_ptr], {28'b0, slot} + 32'd1);
        own_first = next_kept(buf_keep[rd_ptr], 0);
        oth_first = next_kept(buf_keep[~rd_ptr], 0);
        new_first = next_kept(new_keep, 0);
        out_valid = (state == EMIT);
        out_last  = out_valid && !cur_next[4];
        out_q     = out_valid ? buf_q[rd_ptr][slot]     : '0;
        out_r     = out_valid ? buf_r[rd_ptr][slot]     : '0;
        out_depth = out_valid ? buf_depth[rd_ptr][slot] : '0;
        out_slot  = out_valid ? slot : '0;
        case (state)
            IDLE: begin
                if (buf_valid[rd_ptr]) begin
                    if (own_first[4]) begin
                        state_nx = EMIT;
                        slot_nx  = own_first[3:0];
                    end else begin
                        // Empty-mask buffer: retire it; a batch landing now goes straight out.
                        free_buf  = 1'b1;
                        rd_ptr_nx = ~rd_ptr;
                        if (capture && new_first[4]) begin
                            state_nx = EMIT;
                            slot_nx  = new_first[3:0];
                        end
                    end
                end else if (capture && new_first[4]) begin
                    state_nx = EMIT;
                    slot_nx  = new_first[3:0];
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (cur_next[4]) begin
                        slot_nx = cur_next[3:0];
                    end else begin
                        free_buf  = 1'b1;
                        rd_ptr_nx = ~rd_ptr;
                        state_nx  = IDLE;
                        if (buf_valid[~rd_ptr]) begin
                            if (oth_first[4]) begin
                                state_nx = EMIT;
                                slot_nx  = oth_first[3:0];
                            end
                        end else if (capture && new_first[4]) begin
                            state_nx = EMIT;
                            slot_nx  = new_first[3:0];
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            occupancy <= '0;
            buf_valid <= '0;
            overflow  <= 1'b0;
        end else begin
            state  <= state_nx;
            slot   <= slot_nx;
            rd_ptr <= rd_ptr_nx;
            if (capture && !free_buf)
                occupancy <= occupancy + 2'd1;
            else if (!capture && free_buf)
                occupancy <= occupancy - 2'd1;
            if (free_buf)
                buf_valid[rd_ptr] <= 1'b0;
            if (capture) begin
                buf_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end
            if (valid_in && !in_ready)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            buf_keep[wr_ptr] <= new_keep;
            for (int unsigned i = 0; i < BATCH; i++) begin
                buf_q[wr_ptr][i]     <= q_in[i];
                buf_r[wr_ptr][i]     <= r_in[i];
                buf_depth[wr_ptr][i] <= depth_in[i];
            end
        end
    end

`ifdef HEX_CLIP_EN
    logic [4:0]  n_clip;
    logic [16:0] clip_sum;

    always_comb begin
        n_clip = '0;
        for (int unsigned i = 0; i < BATCH; i++) begin
            new_keep[i] = within_radius(q_in[i], r_in[i]);
            n_clip      = n_clip + {4'b0, ~new_keep[i]};
        end
        clip_sum = {1'b0, clip_count} + {12'b0, n_clip};
    end

    always_ff @(posedge clk) begin
        if (reset)
            clip_count <= '0;
        else if (capture)
            clip_count <= clip_sum[16] ? '1 : clip_sum[15:0];
    end
`else
    assign new_keep   = '1;
    assign clip_count = '0;
`endif

endmodule

// File: tb/tb_hex_frag_serializer.sv
// Randomized bench for hex_frag_serializer against a fragment-queue reference model.
// Clip scenarios run only when HEX_CLIP_EN is defined for both bench and design.
module tb_hex_frag_serializer;
    localparam int BATCH  = 10;
    localparam int RADIUS = 64;

    logic               clk = 1'b0;
    logic               reset, valid_in, out_ready;
    logic signed [15:0] q_in     [0:BATCH-1];
    logic signed [15:0] r_in     [0:BATCH-1];
    logic        [7:0]  depth_in [0:BATCH-1];
    logic               in_ready, out_valid, out_last, overflow;
    logic signed [15:0] out_q, out_r;
    logic        [7:0]  out_depth;
    logic        [3:0]  out_slot;
    logic        [15:0] clip_count;

    always #5 clk = ~clk;

    hex_frag_serializer #(.BATCH(BATCH), .RADIUS(RADIUS)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .q_in(q_in), .r_in(r_in), .depth_in(depth_in),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_depth(out_depth),
        .out_slot(out_slot), .out_last(out_last),
        .overflow(overflow), .clip_count(clip_count)
    );

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [7:0]  d;
        logic [3:0]  slot;
        logic        last;
    } frag_t;

    frag_t exp_q[$];
    int    occ_m     = 0;
    int    zero_pend = 0;
    int    clip_m    = 0;
    logic  ovf_m     = 1'b0;
    int    n_vec     = 0;
    int    n_err     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit keep_cell(input int q, input int r);
`ifdef HEX_CLIP_EN
        int m;
        m = (q < 0) ? -q : q;
        if (((r < 0) ? -r : r) > m) m = (r < 0) ? -r : r;
        if (((q + r < 0) ? -(q + r) : q + r) > m) m = (q + r < 0) ? -(q + r) : q + r;
        return m <= RADIUS;
`else
        return 1'b1;
`endif
    endfunction

    // One clock: compare outputs against the model, then advance the model across the edge.
    task automatic step();
        bit    exp_valid, rdy, hs;
        frag_t f;
        int    last_slot;
        exp_valid = (exp_q.size() != 0);
        rdy       = (occ_m < 2);
        f         = '0;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("in_ready", 32'(in_ready), 32'(rdy));
        check("overflow", 32'(overflow), 32'(ovf_m));
        check("clip_count", 32'(clip_count), 32'(clip_m));
        if (exp_valid) begin
            f = exp_q[0];
            check("out_q", 32'($unsigned(out_q)), 32'(f.q));
            check("out_r", 32'($unsigned(out_r)), 32'(f.r));
            check("out_depth", 32'(out_depth), 32'(f.d));
            check("out_slot", 32'(out_slot), 32'(f.slot));
            check("out_last", 32'(out_last), 32'(f.last));
        end
        hs = exp_valid && out_ready;
        if (reset) begin
            exp_q.delete();
            occ_m = 0; zero_pend = 0; clip_m = 0; ovf_m = 1'b0;
        end else begin
            if (hs) begin
                void'(exp_q.pop_front());
                if (f.last) occ_m--;
            end
            if (zero_pend != 0) begin
                occ_m--;
                zero_pend = 0;
            end
            if (valid_in) begin
                if (rdy) begin
                    last_slot = -1;
                    for (int i = 0; i < BATCH; i++)
                        if (keep_cell(int'(q_in[i]), int'(r_in[i]))) last_slot = i;
                    for (int i = 0; i < BATCH; i++) begin
                        if (keep_cell(int'(q_in[i]), int'(r_in[i])))
                            exp_q.push_back({q_in[i], r_in[i], depth_in[i], 4'(i), (i == last_slot)});
                        else if (clip_m < 65535)
                            clip_m++;
                    end
                    if (last_slot < 0) zero_pend = 1;
                    occ_m++;
                end else begin
                    ovf_m = 1'b1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_seq();
        for (int i = 0; i < BATCH; i++) begin
            q_in[i] = 16'(i); r_in[i] = 16'(i); depth_in[i] = 8'(i);
        end
    endtask

    task automatic set_rand();
        int span;
`ifdef HEX_CLIP_EN
        span = 80;
`else
        span = 32767;
`endif
        for (int i = 0; i < BATCH; i++) begin
            q_in[i]     = 16'(int'($urandom_range(0, 2 * span)) - span);
            r_in[i]     = 16'(int'($urandom_range(0, 2 * span)) - span);
            depth_in[i] = 8'($urandom_range(0, 255));
        end
        q_in[0] = '0;
        r_in[0] = '0;
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; out_ready = 1'b0;
        set_seq();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // single sequential batch, downstream always ready
        out_ready = 1'b1; valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (12) step();

        // three batches against a stalled sink: third must overflow
        out_ready = 1'b0;
        repeat (3) begin
            set_rand(); valid_in = 1'b1; step();
        end
        valid_in = 1'b0;
        step();
        out_ready = 1'b1;
        repeat (25) step();

        // two queued batches drained with ready toggling 1010...
        out_ready = 1'b0;
        repeat (2) begin
            set_rand(); valid_in = 1'b1; step();
        end
        valid_in = 1'b0;
        for (int i = 0; i < 45; i++) begin
            out_ready = (i % 2 == 0);
            step();
        end

        // reset while the 4th fragment is presented
        out_ready = 1'b1;
        set_seq(); valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (10) step();

`ifdef HEX_CLIP_EN
        set_seq();
        q_in[3] = 16'sd65; r_in[3] = 16'sd0;
        q_in[9] = 16'sd40; r_in[9] = 16'sd30;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (10) step();
        check("clip_two_cells", 32'(clip_count), 32'd2);

        for (int i = 0; i < BATCH; i++) q_in[i] = 16'sd100;
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
        repeat (3) step();
        check("clip_full_batch", 32'(clip_count), 32'd12);
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_rand();
            valid_in  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        valid_in = 1'b0; out_ready = 1'b1;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hex_frag_serializer.md
HEX_FRAG_SERIALIZER -- requirements
Module: hex_frag_serializer

Interface
REQ-001 Parameter BATCH, default 10, number of cube-rounded hex cells delivered per input beat.
REQ-002 Parameter RADIUS, default 64, inclusive hex-distance clip limit, used only under HEX_CLIP_EN.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_in  input  1  batch present on q_in/r_in/depth_in this cycle.
REQ-006 q_in[0:BATCH-1], r_in[0:BATCH-1]  input  16 each, signed  axial hex coordinates.
REQ-007 depth_in[0:BATCH-1]  input  8 each  per-cell depth.
REQ-008 in_ready  output  1  at least one batch buffer free.
REQ-009 out_valid  output  1  fragment present on out_* this cycle.
REQ-010 out_ready  input  1  downstream accepts fragment.
REQ-011 out_q, out_r  output  16 each, signed  fragment coordinates.
REQ-012 out_depth  output  8  fragment depth.
REQ-013 out_slot  output  4  source slot index within batch.
REQ-014 out_last  output  1  final emitted fragment of its batch.
REQ-015 overflow  output  1  sticky: a batch arrived while in_ready was low.
REQ-016 clip_count  output  16  saturating count of cells discarded by clipping.

Function
REQ-017 Two batch buffers, written in ping-pong order; occupancy counter 0..2; in_ready = (occupancy < 2), driven from registered state only.
REQ-018 valid_in with in_ready high captures all BATCH cells plus a BATCH-bit keep mask into the write buffer.
REQ-019 valid_in with in_ready low drops the batch, sets overflow, leaves buffers unchanged.
REQ-020 Read side FSM: IDLE (occupancy 0 or no kept cell pending) -> EMIT (presenting a fragment) -> IDLE after the out_last handshake when the other buffer is empty; otherwise stays in EMIT on the next buffer.
REQ-021 Fragments are emitted in ascending slot order, skipping slots whose keep bit is 0 with zero cycles spent per skipped slot.
REQ-022 First fragment of a batch captured at cycle N shall be valid at cycle N+1 when the read side is idle.
REQ-023 Once out_valid is high, out_q/out_r/out_depth/out_slot/out_last stay stable until the out_ready handshake.
REQ-024 Sustained throughput: one fragment per cycle while out_ready is high, including across buffer boundaries.
REQ-025 out_last is asserted on the highest-index kept slot; its handshake frees the buffer that cycle; the freed slot is visible on in_ready the following cycle.
REQ-026 A batch with an all-zero keep mask is freed one cycle after capture with no fragment emitted.
REQ-027 Simultaneous capture and free in one cycle leave occupancy unchanged.
REQ-028 clip_count saturates at 16'hFFFF and is incremented by the number of cells clipped in each captured batch.

Reset
REQ-029 On reset: occupancy 0, both buffers invalid, FSM IDLE, out_valid 0, out_last 0, out_q/out_r/out_depth/out_slot 0, overflow 0, clip_count 0, in_ready 1 on the following cycle.
REQ-030 Reset mid-batch discards all buffered fragments; none are emitted after reset is released.

Configuration
REQ-031 Macro HEX_CLIP_EN defined: keep bit = (max(|q|,|r|,|q+r|) <= RADIUS), with 17-bit signed arithmetic for q+r so that no overflow occurs.
REQ-032 HEX_CLIP_EN undefined: every keep bit is 1, clip_count is held at 0, and the no-kept-cell path of REQ-026 is unreachable.

Verification
REQ-033 Reset, then one batch q=r=0..9 with depth=slot and out_ready held at 1 -> out_valid for cycles 1..10, out_slot 0..9, out_last only on slot 9.
REQ-034 Three back-to-back batches with out_ready=0 -> in_ready low after two captures, third batch sets overflow=1, first two batches are later emitted intact.
REQ-035 HEX_CLIP_EN, RADIUS=64, slot 3 q=65 r=0, slot 9 q=40 r=30 (|q+r|=70) -> slots 3 and 9 are skipped, out_last is on slot 8, clip_count=2.
REQ-036 HEX_CLIP_EN, all cells q=100 -> no out_valid, buffer freed next cycle, clip_count=10.
REQ-037 out_ready toggling 1010... across two queued batches -> payload is stable on stalls, 20 fragments in order, and no gap at the buffer switch when ready is high.
REQ-038 Reset asserted on the 4th fragment of a batch -> out_valid=0 the next cycle, occupancy 0, and no residual fragments afterward.
